// File: rtl/reg_file_scoreboard.sv
// Decode-stage register file: multi-port combinational reads with write bypass,
// per-register busy scoreboard, and a sequential clear engine run after reset or on request.
module reg_file_scoreboard #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear_req,
  output logic                             ready,
  input  logic [NUM_READ*$clog2(DEPTH)-1:0] read_address,
  output logic [NUM_READ*DATA_WIDTH-1:0]   read_data,
  output logic [NUM_READ-1:0]              read_busy,
  input  logic                             issue_valid,
  input  logic [$clog2(DEPTH)-1:0]         issue_address,
  input  logic                             write_enable,
  input  logic [$clog2(DEPTH)-1:0]         write_address,
  input  logic [DATA_WIDTH-1:0]            write_data
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [0:0]            state, state_nxt;
  logic [ADDR_W-1:0]     clear_ptr, clear_ptr_nxt;
  logic [DEPTH-1:0]      busy, busy_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  idle;

  assign idle  = (state == ST_IDLE);
  assign ready = idle;

  // State, clear pointer and scoreboard registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_CLEAR;
      clear_ptr <= '0;
      busy      <= '0;
    end else begin
      state     <= state_nxt;
      clear_ptr <= clear_ptr_nxt;
      busy      <= busy_nxt;
    end
  end

  // Storage array is deliberately not reset; the clear engine zeroes it instead
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // Next-state, clear sweep, writeback and scoreboard update
  always_comb begin
    state_nxt     = state;
    clear_ptr_nxt = clear_ptr;
    busy_nxt      = busy;
    mem_we        = 1'b0;
    mem_addr      = write_address;
    mem_wdata     = write_data;
    case (state)
      ST_CLEAR: begin
        mem_we        = 1'b1;
        mem_addr      = clear_ptr;
        mem_wdata     = '0;
        busy_nxt      = '0;
        clear_ptr_nxt = clear_ptr + ADDR_W'(1);
        if (clear_ptr == ADDR_W'(DEPTH - 1)) state_nxt = ST_IDLE;
      end
      default: begin
        if (clear_req) begin
          state_nxt     = ST_CLEAR;
          clear_ptr_nxt = '0;
          busy_nxt      = '0;
        end else begin
          mem_we = write_enable && (write_address != '0);
          if (write_enable) busy_nxt[write_address] = 1'b0;
          // A new producer issued on the writeback edge keeps the register pending
          if (issue_valid && (issue_address != '0)) busy_nxt[issue_address] = 1'b1;
        end
      end
    endcase
  end

  // Read ports: zero while clearing or for r0, else bypass or stored value
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_hit;
  always_comb begin
    read_data = '0;
    read_busy = '0;
    rd_addr   = '0;
    rd_hit    = 1'b0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      rd_addr = read_address[i*ADDR_W +: ADDR_W];
      rd_hit  = (BYPASS != 0) && write_enable && (write_address == rd_addr);
      if (idle && (rd_addr != '0)) begin
        read_data[i*DATA_WIDTH +: DATA_WIDTH] = rd_hit ? write_data : mem[rd_addr];
        read_busy[i]                          = busy[rd_addr] && !rd_hit;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Self-checking bench for reg_file_scoreboard: directed vector table, clear/reset
// sequences and randomized traffic against an array-based reference model.
module tb_reg_file_scoreboard;

  localparam int DW = 32;
  localparam int D  = 32;
  localparam int NR = 2;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear_req;
  logic          issue_valid, write_enable;
  logic [AW-1:0] issue_address, write_address;
  logic [DW-1:0] write_data;
  logic [NR*AW-1:0] read_address;

  logic             ready, ready_nb;
  logic [NR*DW-1:0] read_data, read_data_nb;
  logic [NR-1:0]    read_busy, read_busy_nb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_file_scoreboard #(.DATA_WIDTH(DW), .DEPTH(D), .NUM_READ(NR), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready),
    .read_address(read_address), .read_data(read_data), .read_busy(read_busy),
    .issue_valid(issue_valid), .issue_address(issue_address),
    .write_enable(write_enable), .write_address(write_address), .write_data(write_data)
  );

  reg_file_scoreboard #(.DATA_WIDTH(DW), .DEPTH(D), .NUM_READ(NR), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready_nb),
    .read_address(read_address), .read_data(read_data_nb), .read_busy(read_busy_nb),
    .issue_valid(issue_valid), .issue_address(issue_address),
    .write_enable(write_enable), .write_address(write_address), .write_data(write_data)
  );

  // Reference model: contents, pending flags, and edges left before the array is usable
  logic [DW-1:0] m_mem [D];
  bit            m_busy [D];
  int            m_left;

  function automatic logic [DW-1:0] exp_rd(int a, bit bp);
    if (m_left > 0 || a == 0) return '0;
    if (bp && write_enable && int'(write_address) == a) return write_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_rb(int a, bit bp);
    if (m_left > 0 || a == 0) return 1'b0;
    if (bp && write_enable && int'(write_address) == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_wipe(int edges);
    m_left = edges;
    for (int k = 0; k < D; k++) begin
      m_mem[k]  = '0;
      m_busy[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (m_left > 0) m_left--;
    else if (clear_req) model_wipe(D);
    else begin
      if (write_enable && write_address != 0) m_mem[write_address] = write_data;
      if (write_enable) m_busy[write_address] = 1'b0;
      if (issue_valid && issue_address != 0) m_busy[issue_address] = 1'b1;
    end
  endtask

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    #1;
    chk("ready", DW'(ready), DW'(m_left == 0));
    chk("ready_nb", DW'(ready_nb), DW'(m_left == 0));
    for (int i = 0; i < NR; i++) begin
      int a;
      a = int'(read_address[i*AW +: AW]);
      chk($sformatf("rd%0d a%0d", i, a), read_data[i*DW +: DW], exp_rd(a, 1'b1));
      chk($sformatf("rb%0d a%0d", i, a), DW'(read_busy[i]), DW'(exp_rb(a, 1'b1)));
      chk($sformatf("nb_rd%0d a%0d", i, a), read_data_nb[i*DW +: DW], exp_rd(a, 1'b0));
      chk($sformatf("nb_rb%0d a%0d", i, a), DW'(read_busy_nb[i]), DW'(exp_rb(a, 1'b0)));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clear_req = 0; issue_valid = 0; issue_address = '0;
    write_enable = 0; write_address = '0; write_data = '0;
  endtask

  // Counts edges until ready, optionally re-pulsing clear_req at edge poke_at
  task automatic count_to_ready(input int poke_at, output int n);
    n = 0;
    while (!ready && n < 100) begin
      clear_req = (n == poke_at);
      tick();
      n++;
      clear_req = 0;
      check_all();
    end
  endtask

  task automatic sweep_reads();
    for (int a = 0; a < D; a++) begin
      read_address = {AW'((a + 1) % D), AW'(a)};
      check_all();
    end
  endtask

  typedef struct {
    bit we; logic [AW-1:0] wa; logic [DW-1:0] wd;
    bit iv; logic [AW-1:0] ia;
    logic [AW-1:0] ra0, ra1;
    logic [DW-1:0] e0, e1;
    bit b0, b1;
  } vec_t;

  vec_t vt [13];
  int   n;

  initial begin
    vt[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 32'hDEADBEEF, 32'h0, 0, 0};
    vt[1]  = '{0, 0, 32'h0,        0, 0, 5, 0, 32'hDEADBEEF, 32'h0, 0, 0};
    vt[2]  = '{1, 0, 32'h12345678, 1, 0, 0, 5, 32'h0, 32'hDEADBEEF, 0, 0};
    vt[3]  = '{0, 0, 32'h0,        1, 7, 0, 7, 32'h0, 32'h0, 0, 0};
    vt[4]  = '{0, 0, 32'h0,        0, 0, 7, 0, 32'h0, 32'h0, 1, 0};
    vt[5]  = '{0, 0, 32'h0,        0, 0, 7, 7, 32'h0, 32'h0, 1, 1};
    vt[6]  = '{1, 7, 32'hAAAA5555, 0, 0, 7, 7, 32'hAAAA5555, 32'hAAAA5555, 0, 0};
    vt[7]  = '{0, 0, 32'h0,        0, 0, 7, 5, 32'hAAAA5555, 32'hDEADBEEF, 0, 0};
    vt[8]  = '{0, 0, 32'h0,        1, 7, 7, 0, 32'hAAAA5555, 32'h0, 0, 0};
    vt[9]  = '{1, 7, 32'h11112222, 1, 7, 7, 7, 32'h11112222, 32'h11112222, 0, 0};
    vt[10] = '{0, 0, 32'h0,        0, 0, 7, 7, 32'h11112222, 32'h11112222, 1, 1};
    vt[11] = '{1, 7, 32'h33334444, 0, 0, 5, 7, 32'hDEADBEEF, 32'h33334444, 0, 0};
    vt[12] = '{0, 0, 32'h0,        0, 0, 7, 0, 32'h33334444, 32'h0, 0, 0};

    idle_inputs();
    read_address = '0;
    model_wipe(D);
    repeat (3) @(negedge clk);
    #1 chk("reset_ready", DW'(ready), 32'h0);
    rst_n = 1;

    // Clear after reset release takes exactly DEPTH edges
    check_all();
    count_to_ready(-1, n);
    chk("reset_clear_edges", DW'(n), 32'd32);
    sweep_reads();

    // Directed table: bypass, r0 handling, scoreboard set/clear ordering
    for (int k = 0; k < 13; k++) begin
      write_enable = vt[k].we; write_address = vt[k].wa; write_data = vt[k].wd;
      issue_valid = vt[k].iv; issue_address = vt[k].ia;
      read_address = {vt[k].ra1, vt[k].ra0};
      check_all();
      chk($sformatf("vec%0d rd0", k), read_data[DW-1:0], vt[k].e0);
      chk($sformatf("vec%0d rd1", k), read_data[2*DW-1:DW], vt[k].e1);
      chk($sformatf("vec%0d rb0", k), DW'(read_busy[0]), DW'(vt[k].b0));
      chk($sformatf("vec%0d rb1", k), DW'(read_busy[1]), DW'(vt[k].b1));
      if (k == 0) chk("nobypass same-cycle", read_data_nb[DW-1:0], 32'h0);
      if (k == 1) chk("nobypass next-cycle", read_data_nb[DW-1:0], 32'hDEADBEEF);
      tick();
    end
    idle_inputs();

    // Fill r1..r31 with some pending producers, then a requested clear with a mid-clear re-request
    for (int a = 1; a < D; a++) begin
      write_enable = 1; write_address = AW'(a); write_data = $urandom;
      issue_valid = (a % 3 == 0); issue_address = AW'((a + 5) % D);
      tick();
    end
    idle_inputs();
    sweep_reads();
    clear_req = 1;
    read_address = {AW'(9), AW'(3)};
    check_all();
    tick();
    clear_req = 0;
    check_all();
    count_to_ready(10, n);
    chk("request_clear_edges", DW'(n), 32'd32);
    sweep_reads();

    // Reset pulse in the middle of a clear restarts the full sweep
    write_enable = 1; write_address = 5'd12; write_data = 32'hCAFEF00D;
    tick();
    idle_inputs();
    clear_req = 1;
    tick();
    clear_req = 0;
    repeat (10) tick();
    chk("midclear_not_ready", DW'(ready), 32'h0);
    rst_n = 0;
    model_wipe(D);
    #2 chk("reset_during_clear", DW'(ready), 32'h0);
    rst_n = 1;
    check_all();
    count_to_ready(-1, n);
    chk("reset_restart_edges", DW'(n), 32'd32);
    sweep_reads();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      write_enable  = 1'($urandom_range(0, 1));
      write_address = AW'($urandom_range(0, D - 1));
      write_data    = $urandom;
      issue_valid   = 1'($urandom_range(0, 1));
      issue_address = ($urandom_range(0, 3) == 0) ? write_address : AW'($urandom_range(0, D - 1));
      clear_req     = ($urandom_range(0, 99) == 0);
      read_address  = {AW'($urandom_range(0, D - 1)),
                       ($urandom_range(0, 2) == 0) ? write_address : AW'($urandom_range(0, D - 1))};
      check_all();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
